// File: rtl/ring_token_arbiter_if.sv
// ring_token_arbiter_if
//   Bundles the request/grant signals between N requesting agents and the
//   ring token arbiter.
//
//   Signals:
//     en        arbitration enable (requester side -> arbiter)
//     req       level requests, one bit per requester (requester side -> arbiter)
//     gnt       registered one-hot grant, zero when idle (arbiter -> requesters)
//     gnt_valid high while gnt is non-zero (arbiter -> requesters)
//     owner_id  binary index of the granted requester, 0 when idle
//     token     one-hot ring pointer, marks the highest-priority position
//     timeout   one-cycle pulse on a forced release
//
//   Handshake: a requester raises req[i] and keeps it high for as long as it
//   wants the resource. gnt[i] rises one cycle after the request is first
//   seen by an idle arbiter and stays high until req[i] is sampled low. The
//   grant is then dropped on that same edge, and the arbiter spends one
//   turnaround cycle before it looks at requests again.
//
//   Modports: master = requesting side, slave = arbiter.
interface ring_token_arbiter_if #(
  parameter int N    = 8,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
);
  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] owner_id;
  logic [N-1:0]    token;
  logic            timeout;

  modport master (
    output en, req,
    input  gnt, gnt_valid, owner_id, token, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_valid, owner_id, token, timeout
  );
endinterface

// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter
//   Round-robin arbiter sharing one resource between N requesters. Fairness
//   comes from a rotating one-hot token: an idle arbiter grants the first
//   requesting bit at or above the token position (wrapping from N-1 to 0).
//   A grant is held until the owner drops its request; every release is
//   followed by one turnaround cycle and moves the token one place past the
//   released owner. All outputs are registered.
//
//   Parameters:
//     N        number of requesters (2..16)
//     HOLD_MAX maximum grant-hold cycles before forced release
//     CNT_W    width of the hold counter, must be able to hold HOLD_MAX
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     bus        ring_token_arbiter_if.slave (en, req in; gnt, gnt_valid,
//                owner_id, token, timeout out)
//     fsm_state  current FSM state (0 = IDLE, 1 = GRANT, 2 = TURN)
//
//   Optional feature, macro RR_TIMEOUT_EN:
//     defined   - grants are force-released after HOLD_MAX cycles, timeout
//                 pulses for one cycle, and the timed-out requester is masked
//                 from arbitration until its req is sampled low.
//     undefined - grant hold is unbounded and timeout is tied low.
module ring_token_arbiter #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ring_token_arbiter_if.slave  bus,
  output logic [1:0]           fsm_state
);

  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    gnt_q;
  logic            gnt_valid_q;
  logic [ID_W-1:0] owner_q;
  logic [N-1:0]    token_q;

  logic [N-1:0]    req_eff;
  logic [ID_W-1:0] tok_idx;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  logic            forced;
  logic            release_now;

`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic [N-1:0]     mask_q;
  logic             timeout_q;

  // A requester that timed out is invisible to arbitration until it has
  // been seen with req low at least once.
  assign req_eff = bus.req & ~mask_q;

  // The forced release happens on the edge that would take the counter to
  // HOLD_MAX, so the grant is visible for exactly HOLD_MAX cycles.
  assign forced  = (state == S_GRANT) && bus.req[owner_q] &&
                   (hold_cnt == CNT_W'(HOLD_MAX - 1));
`else
  assign req_eff = bus.req;
  assign forced  = 1'b0;
`endif

  assign release_now = (state == S_GRANT) && (!bus.req[owner_q] || forced);

  // Binary position of the token.
  always_comb begin
    tok_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (token_q[i]) tok_idx = ID_W'(i);
    end
  end

  // Token-relative search. Walking offsets from N-1 down to 0 lets the
  // smallest offset from the token overwrite any larger one, so the winner
  // is the first requester at or after the token, wrapping past N-1.
  always_comb begin : search
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    sum        = '0;
    idx        = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, tok_idx} + (ID_W + 1)'(i);
      if (sum >= (ID_W + 1)'(N)) sum = sum - (ID_W + 1)'(N);
      idx = sum[ID_W-1:0];
      if (req_eff[idx]) begin
        pick_idx   = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      owner_q     <= '0;
      token_q     <= {{(N-1){1'b0}}, 1'b1};
`ifdef RR_TIMEOUT_EN
      hold_cnt    <= '0;
      mask_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef RR_TIMEOUT_EN
      timeout_q <= 1'b0;
      mask_q    <= mask_q & bus.req;
`endif
      case (state)
        S_IDLE: begin
          if (bus.en && pick_found) begin
            state       <= S_GRANT;
            gnt_q       <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            gnt_valid_q <= 1'b1;
            owner_q     <= pick_idx;
`ifdef RR_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end
        end

        S_GRANT: begin
          // en and other requests are deliberately ignored while granted.
          if (release_now) begin
            state       <= S_TURN;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            owner_q     <= '0;
            // Token moves one place past the released owner.
            token_q     <= {gnt_q[N-2:0], gnt_q[N-1]};
`ifdef RR_TIMEOUT_EN
            if (forced) begin
              timeout_q       <= 1'b1;
              mask_q[owner_q] <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end

        S_TURN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.owner_id  = owner_q;
  assign bus.token     = token_q;
`ifdef RR_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif
  assign fsm_state     = state;

endmodule
